// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared constants, digit-count helper and state encoding for the Booth digit streamer
package booth_pkg;

  // Booth triplet codes {B[2i+1],B[2i],B[2i-1]}
  localparam logic [2:0] SEL_ZERO_P = 3'b000;
  localparam logic [2:0] SEL_P1A    = 3'b001;
  localparam logic [2:0] SEL_P1B    = 3'b010;
  localparam logic [2:0] SEL_P2     = 3'b011;
  localparam logic [2:0] SEL_M2     = 3'b100;
  localparam logic [2:0] SEL_M1A    = 3'b101;
  localparam logic [2:0] SEL_M1B    = 3'b110;
  localparam logic [2:0] SEL_ZERO_N = 3'b111;

  // Number of radix-4 digits needed to cover an n-bit signed multiplier
  function automatic int n_digits(input int n);
    return (n + 1) / 2;
  endfunction

  // Width of a digit index for d digits, never narrower than one bit
  function automatic int idx_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } booth_state_e;

endpackage

// File: rtl/booth_digit_streamer_if.sv
// rtl/booth_digit_streamer_if.sv - load and digit-stream handshake bundle
interface booth_digit_streamer_if
  import booth_pkg::*;
#(
  parameter int N = 10
);
  localparam int D  = n_digits(N);
  localparam int IW = idx_width(D);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  b_in;
  logic          skip_zero;
  logic          sel_valid;
  logic          sel_ready;
  logic [2:0]    sel;
  logic [IW-1:0] digit_idx;
  logic          neg;
  logic          last;

  // Side that supplies operands and consumes digits
  modport master (
    output in_valid, b_in, skip_zero, sel_ready,
    input  in_ready, sel_valid, sel, digit_idx, neg, last
  );

  // The recoder itself
  modport slave (
    input  in_valid, b_in, skip_zero, sel_ready,
    output in_ready, sel_valid, sel, digit_idx, neg, last
  );

endinterface

// File: rtl/booth_digit_enc.sv
// rtl/booth_digit_enc.sv - classifies one Booth triplet as zero and/or negative
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [2:0] sel,
  output logic       zero,
  output logic       neg
);

  // 000 and 111 both select a zero partial product; a set top bit otherwise means subtract
  always_comb begin
    zero = (sel == SEL_ZERO_P) || (sel == SEL_ZERO_N);
    neg  = sel[2] & ~zero;
  end

endmodule

// File: rtl/booth_digit_streamer.sv
// rtl/booth_digit_streamer.sv - sequential radix-4 Booth recoder streaming one digit per beat
module booth_digit_streamer
  import booth_pkg::*;
#(
  parameter int N = 10
)(
  input  logic                   clk,
  input  logic                   rst_n,
  booth_digit_streamer_if.slave  bus
);

  localparam int D  = n_digits(N);
  localparam int IW = idx_width(D);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_EMIT = EMIT;

  logic [0:0]    state;
  logic [2:0]    store [D];
  logic [D-1:0]  pending;
  logic          skip_r;

  logic [2*D:0]  bx;
  logic [2:0]    trip [D];
  logic [D-1:0]  dzero;
  logic [D-1:0]  dneg;
  logic          all_zero;
  logic [D-1:0]  emit_mask;
  logic [IW-1:0] cur_j;
  logic          cur_last;
  logic [2:0]    out_sel;
  logic          out_zero;
  logic          out_neg;
  logic          emitting;
  logic          beat_done;
  logic          unused_enc_bits;

  assign emitting  = (state == S_EMIT);
  assign beat_done = emitting && bus.sel_ready;

  // Extend the operand with B[-1]=0 below and sign bits above, then slice overlapping triplets
  always_comb begin
    bx    = '0;
    bx[0] = 1'b0;
    for (int k = 0; k < 2 * D; k++) begin
      if (k < N) bx[k+1] = bus.b_in[k];
      else       bx[k+1] = bus.b_in[N-1];
    end
    for (int i = 0; i < D; i++) begin
      trip[i] = {bx[2*i+2], bx[2*i+1], bx[2*i]};
    end
  end

  // Per-digit zero flags of the stored operand drive the zero-skip decision
  for (genvar g = 0; g < D; g++) begin : g_enc
    booth_digit_enc u_enc (
      .sel  (store[g]),
      .zero (dzero[g]),
      .neg  (dneg[g])
    );
  end

  assign all_zero = &dzero;

  // A pending digit is emitted unless zero-skip drops it; the top digit survives only for an all-zero operand
  always_comb begin
    emit_mask = '0;
    for (int i = 0; i < D; i++) begin
      emit_mask[i] = pending[i] &
                     (~skip_r | ~dzero[i] | ((i == D - 1) & all_zero));
    end
  end

  // Current digit is the lowest emittable one; it is last when nothing emittable lies above it
  always_comb begin
    cur_j    = '0;
    cur_last = 1'b1;
    for (int i = D - 1; i >= 0; i--) begin
      if (emit_mask[i]) cur_j = IW'(i);
    end
    for (int i = 0; i < D; i++) begin
      if (emit_mask[i] && (i > int'(cur_j))) cur_last = 1'b0;
    end
  end

  // Outputs are held at zero while idle so the bus reads clean after reset
  assign out_sel = emitting ? store[cur_j] : 3'b000;

  booth_digit_enc u_out_enc (
    .sel  (out_sel),
    .zero (out_zero),
    .neg  (out_neg)
  );

  // Per-digit negate flags and the output zero flag have no consumer here
  assign unused_enc_bits = ^{dneg, out_zero};

  assign bus.in_ready  = ~emitting;
  assign bus.sel_valid = emitting;
  assign bus.sel       = out_sel;
  assign bus.digit_idx = emitting ? cur_j : '0;
  assign bus.neg       = out_neg;
  assign bus.last      = emitting & cur_last;

  // Load captures every triplet at once; each accepted beat retires all digits up to the one shown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pending <= '0;
      skip_r  <= 1'b0;
      for (int i = 0; i < D; i++) store[i] <= 3'b000;
    end else if (!emitting) begin
      if (bus.in_valid) begin
        state   <= S_EMIT;
        pending <= '1;
        skip_r  <= bus.skip_zero;
        for (int i = 0; i < D; i++) store[i] <= trip[i];
      end
    end else if (beat_done) begin
      for (int i = 0; i < D; i++) begin
        if (i <= int'(cur_j)) pending[i] <= 1'b0;
      end
      if (cur_last) state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_booth_digit_streamer.sv
// tb/tb_booth_digit_streamer.sv - self-checking bench for the Booth digit streamer
module tb_booth_digit_streamer;

  localparam int N = 10;
  localparam int D = (N + 1) / 2;

  typedef struct {
    int sel;
    int idx;
    int neg;
    int last;
  } beat_t;

  logic clk;
  logic rst_n;

  booth_digit_streamer_if #(.N(N)) bus ();

  booth_digit_streamer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t mq[$];
  beat_t exp_q[$];
  int    exp_val[$];
  int    acc = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Signed value a triplet code contributes at its digit weight
  function automatic int val_of(input int s);
    case (s)
      1, 2:    return 1;
      3:       return 2;
      4:       return -2;
      5, 6:    return -1;
      default: return 0;
    endcase
  endfunction

  // Expected beat list for operand b: triplets from the doubled operand, then zero-skip filtering
  task automatic model(input int b, input bit skip);
    int s [D];
    int nz;
    mq.delete();
    nz = 0;
    for (int i = 0; i < D; i++) begin
      s[i] = ((b * 2) >>> (2 * i)) & 7;
      if (val_of(s[i]) != 0) nz++;
    end
    for (int i = 0; i < D; i++) begin
      if (!skip || val_of(s[i]) != 0 || (i == D - 1 && nz == 0)) begin
        beat_t bt;
        bt.sel  = s[i];
        bt.idx  = i;
        bt.neg  = (val_of(s[i]) < 0) ? 1 : 0;
        bt.last = 0;
        mq.push_back(bt);
      end
    end
    mq[mq.size()-1].last = 1;
  endtask

  // Monitor: every handshake is compared with the model, stalls must hold outputs steady
  bit        prev_stall = 0;
  bit        after_last = 0;
  logic [2:0] p_sel;
  int        p_idx, p_neg, p_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc        = 0;
      prev_stall = 0;
      after_last = 0;
    end else begin
      if (after_last) begin
        chk("in_ready_after_last", int'(bus.in_ready), 1);
        chk("sel_valid_after_last", int'(bus.sel_valid), 0);
        after_last = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", int'(bus.sel_valid), 1);
        chk("stall_sel", int'(bus.sel), int'(p_sel));
        chk("stall_idx", int'(bus.digit_idx), p_idx);
        chk("stall_neg", int'(bus.neg), p_neg);
        chk("stall_last", int'(bus.last), p_last);
      end
      if (bus.sel_valid) chk("in_ready_during_emit", int'(bus.in_ready), 0);
      if (bus.sel_valid && bus.sel_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_idx", int'(bus.digit_idx), -1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_sel", int'(bus.sel), e.sel);
          chk("beat_idx", int'(bus.digit_idx), e.idx);
          chk("beat_neg", int'(bus.neg), e.neg);
          chk("beat_last", int'(bus.last), e.last);
          acc += val_of(int'(bus.sel)) * (1 << (2 * int'(bus.digit_idx)));
          if (bus.last) begin
            if (exp_val.size() > 0) chk("reconstructed_value", acc, exp_val.pop_front());
            acc = 0;
            after_last = 1;
          end
        end
      end
      prev_stall = bus.sel_valid && !bus.sel_ready;
      p_sel  = bus.sel;
      p_idx  = int'(bus.digit_idx);
      p_neg  = int'(bus.neg);
      p_last = int'(bus.last);
    end
  end

  task automatic load(input int b, input bit skip);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk("load_wait_timeout", 0, 1);
    model(b, skip);
    foreach (mq[k]) exp_q.push_back(mq[k]);
    exp_val.push_back(b);
    bus.in_valid  = 1'b1;
    bus.b_in      = b[N-1:0];
    bus.skip_zero = skip;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  // Load one operand and drain it; optionally stall randomly and poke in_valid during the stream
  task automatic run(input int b, input bit skip, input bit stress);
    int n;
    load(b, skip);
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      if (stress) begin
        bus.sel_ready = 1'($urandom_range(0, 1));
        bus.in_valid  = 1'b1;
        bus.b_in      = 10'h2AA;
        bus.skip_zero = 1'b1;
      end else begin
        bus.sel_ready = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.sel_ready = 1'b1;
    if (exp_q.size() > 0) begin
      chk("drain_timeout_left", exp_q.size(), 0);
      exp_q.delete();
      exp_val.delete();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_after_stream", int'(bus.sel_valid), 0);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.b_in      = '0;
    bus.skip_zero = 1'b0;
    bus.sel_ready = 1'b1;

    // Hand-computed pins on the model itself
    model(3, 0);
    chk("model3_size", mq.size(), 5);
    chk("model3_sel0", mq[0].sel, 6);
    chk("model3_sel1", mq[1].sel, 1);
    chk("model3_sel4", mq[4].sel, 0);
    chk("model3_neg0", mq[0].neg, 1);
    chk("model3_last3", mq[3].last, 0);
    chk("model3_last4", mq[4].last, 1);
    model(341, 0);
    chk("model341_sel2", mq[2].sel, 2);
    chk("model341_sel4", mq[4].sel, 2);
    model(-512, 1);
    chk("modelm512_size", mq.size(), 1);
    chk("modelm512_idx", mq[0].idx, 4);
    chk("modelm512_sel", mq[0].sel, 4);
    model(-1, 1);
    chk("modelm1_size", mq.size(), 1);
    chk("modelm1_idx", mq[0].idx, 0);
    chk("modelm1_sel", mq[0].sel, 6);
    model(0, 1);
    chk("model0_size", mq.size(), 1);
    chk("model0_idx", mq[0].idx, 4);
    chk("model0_sel", mq[0].sel, 0);

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_sel_valid", int'(bus.sel_valid), 0);
    chk("reset_sel", int'(bus.sel), 0);
    chk("reset_idx", int'(bus.digit_idx), 0);
    chk("reset_neg", int'(bus.neg), 0);
    chk("reset_last", int'(bus.last), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed streams
    run(3, 0, 0);
    run(341, 0, 0);
    run(-512, 1, 0);
    run(-1, 1, 0);
    run(0, 1, 0);
    run(-512, 0, 0);
    run(0, 0, 0);
    run(-171, 1, 0);
    run(511, 1, 0);
    run(3, 1, 0);

    // First beat appears one cycle after the load edge
    model(3, 0);
    foreach (mq[k]) exp_q.push_back(mq[k]);
    exp_val.push_back(3);
    bus.sel_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.b_in      = 10'd3;
    bus.skip_zero = 1'b0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    chk("latency_sel_valid", int'(bus.sel_valid), 1);
    chk("latency_sel", int'(bus.sel), 6);
    chk("latency_idx", int'(bus.digit_idx), 0);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      bus.sel_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("latency_drain_left", exp_q.size(), 0);
    @(posedge clk); #1;

    // Backpressure with in_valid held during EMIT
    run(3, 0, 1);
    run(-342, 1, 1);
    run(341, 0, 1);

    // Reset in the middle of a stream
    load(341, 0);
    bus.sel_ready = 1'b1;
    n = 0;
    while (!(bus.sel_valid && bus.digit_idx == 2) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx2", int'(bus.digit_idx), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    exp_val.delete();
    chk("midreset_sel_valid", int'(bus.sel_valid), 0);
    chk("midreset_in_ready", int'(bus.in_ready), 1);
    chk("midreset_sel", int'(bus.sel), 0);
    chk("midreset_last", int'(bus.last), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(3, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
